// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bundle linking fetch_unit to instruction memory, decode and hazard logic.
interface fetch_if;
    logic        stall;
    logic        b;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    modport master (
        input  stall, b, branch_target, jump, jump_target, imem_data, imem_ready,
        output imem_addr, id_inst, id_pc4, id_valid
    );
    modport slave (
        output stall, b, branch_target, jump, jump_target, imem_data, imem_ready,
        input  imem_addr, id_inst, id_pc4, id_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction fetch and IF/ID register with branch/jump redirect.
// Define FETCH_DELAY_SLOT_EN for MIPS delay-slot semantics (adds the PENDING state).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    logic [31:0] pc, pc4, tgt, pc_nxt, inst, inst_pc4;
    logic        valid, redirect, fetch;
    assign pc4           = pc + 32'd4;
    assign redirect      = valid & (bus.jump | bus.b);
    assign tgt           = bus.jump ? bus.jump_target : bus.branch_target;
    assign bus.imem_addr = pc;
    assign bus.id_inst   = inst;
    assign bus.id_pc4    = inst_pc4;
    assign bus.id_valid  = valid;
`ifdef FETCH_DELAY_SLOT_EN
    typedef enum logic {NORMAL, PENDING} state_t;
    state_t      state, state_nxt;
    logic [31:0] pend;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= NORMAL;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            if (state == NORMAL && state_nxt == PENDING) pend <= tgt;
        end
    always_comb
        state_nxt = bus.stall ? state
                  : state == NORMAL ? (redirect && !bus.imem_ready ? PENDING : NORMAL)
                  : (bus.imem_ready ? NORMAL : PENDING);
    // The delay slot is always kept, so IF/ID loads whenever memory delivers.
    always_comb begin
        fetch  = bus.imem_ready;
        pc_nxt = !bus.imem_ready ? pc : state == PENDING ? pend : redirect ? tgt : pc4;
    end
`else
    always_comb begin
        fetch  = bus.imem_ready & ~redirect;
        pc_nxt = redirect ? tgt : bus.imem_ready ? pc4 : pc;
    end
`endif
    // stall freezes everything, so a redirect seen under stall is simply dropped.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc       <= RESET_PC;
            inst     <= '0;
            inst_pc4 <= '0;
            valid    <= 1'b0;
        end else if (!bus.stall) begin
            pc       <= pc_nxt;
            inst     <= fetch ? bus.imem_data : 32'h0;
            inst_pc4 <= fetch ? pc4 : 32'h0;
            valid    <= fetch;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan scenarios plus randomized run against a cycle-level reference model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    fetch_if bus();
    fetch_unit #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction
    assign bus.imem_data = word(bus.imem_addr);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    // reference model state
    logic [31:0] m_pc, m_inst, m_pc4, m_ptgt;
    logic        m_valid, m_pend;

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_pend = 0; m_ptgt = 0;
    endtask

    task automatic model_step();
        logic [31:0] t, np;
        logic red, ld;
        t   = bus.jump ? bus.jump_target : bus.branch_target;
        red = m_valid && (bus.jump || bus.b);
        np  = m_pc;
        ld  = bus.imem_ready;
        if (bus.stall) return;
        if (DS) begin
            if (m_pend) begin
                if (bus.imem_ready) begin np = m_ptgt; m_pend = 0; end
            end else if (red && !bus.imem_ready) begin
                m_pend = 1; m_ptgt = t;
            end else if (red) np = t;
            else if (bus.imem_ready) np = m_pc + 4;
        end else begin
            if (red) begin np = t; ld = 0; end
            else if (bus.imem_ready) np = m_pc + 4;
        end
        m_inst  = ld ? word(m_pc) : 32'h0;
        m_pc4   = ld ? m_pc + 32'd4 : 32'h0;
        m_valid = ld;
        m_pc    = np;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall = 0; bus.b = 0; bus.jump = 0;
        bus.branch_target = 0; bus.jump_target = 0;
    endtask

    task automatic test_reset();
        clear_ctl();
        bus.imem_ready = 1;
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus.imem_addr, bus.id_inst, bus.id_pc4, bus.id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset: addr=%h inst=%h pc4=%h valid=%b expected all zero", bus.imem_addr, bus.id_inst, bus.id_pc4, bus.id_valid);
        end
        rst = 0;
    endtask

    task automatic test_sequential();
        bus.imem_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.id_inst !== 32'hA0 + i || bus.id_pc4 !== 4 * (i + 1) || bus.id_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq[%0d]: inst=%h pc4=%h valid=%b expected inst=%h pc4=%h valid=1", i, bus.id_inst, bus.id_pc4, bus.id_valid, 32'hA0 + i, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ea [4];
        logic [31:0] ei [4];
        // branch at 0x10 in ID, target 0x40
        bus.b = 1; bus.branch_target = 32'h40;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.b = 0;
            ei[0] = DS ? 32'hA5 : 32'h0;
            ei[1] = 32'hB0;
            ea[0] = 32'h40; ea[1] = 32'h44;
            checks++;
            if (bus.id_inst !== ei[i] || bus.imem_addr !== ea[i] || bus.id_valid !== (ei[i] != 0)) begin
                failures++;
                $display("FAIL branch[%0d]: inst=%h addr=%h valid=%b expected inst=%h addr=%h", i, bus.id_inst, bus.imem_addr, bus.id_valid, ei[i], ea[i]);
            end
        end
        checks++;
        if (bus.id_pc4 !== 32'h44) begin
            failures++;
            $display("FAIL branch_pc4: got=%h expected=00000044", bus.id_pc4);
        end
        // branch at 0x40 in ID, target 0x20, memory slow for 2 cycles
        bus.b = 1; bus.branch_target = 32'h20; bus.imem_ready = 0;
        if (DS) begin
            ea = '{32'h44, 32'h44, 32'h20, 32'h24}; ei = '{32'h0, 32'h0, 32'hB1, 32'hA8};
        end else begin
            ea = '{32'h20, 32'h20, 32'h24, 32'h28}; ei = '{32'h0, 32'h0, 32'hA8, 32'hA9};
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.b = 0;
            bus.imem_ready = (i >= 1);
            checks++;
            if (bus.id_inst !== ei[i] || bus.imem_addr !== ea[i] || bus.id_valid !== (ei[i] != 0)) begin
                failures++;
                $display("FAIL slow_branch[%0d]: inst=%h addr=%h valid=%b expected inst=%h addr=%h", i, bus.id_inst, bus.imem_addr, bus.id_valid, ei[i], ea[i]);
            end
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] sa, si;
        sa = m_pc; si = m_inst;
        bus.imem_ready = 1; bus.stall = 1; bus.b = 1; bus.branch_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== sa || bus.id_inst !== si) begin
                failures++;
                $display("FAIL stall[%0d]: addr=%h inst=%h expected addr=%h inst=%h", i, bus.imem_addr, bus.id_inst, sa, si);
            end
        end
        bus.stall = 0;
        tick();
        bus.b = 0;
        checks++;
        if (bus.imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL stall_release: addr=%h expected=00000100", bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.imem_addr !== 32'h104 || bus.id_inst !== word(32'h100)) begin
            failures++;
            $display("FAIL single_redirect: addr=%h inst=%h expected addr=00000104 inst=%h", bus.imem_addr, bus.id_inst, word(32'h100));
        end
    endtask

    task automatic test_wrap_jump();
        bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
        tick();
        bus.jump = 0;
        tick();
        checks++;
        if (bus.id_inst !== 32'h4000_009F || bus.id_pc4 !== 32'h0 || bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap: inst=%h pc4=%h addr=%h valid=%b expected inst=4000009f pc4=0 addr=0 valid=1", bus.id_inst, bus.id_pc4, bus.imem_addr, bus.id_valid);
        end
        bus.jump = 1; bus.jump_target = 32'h80; bus.b = 1; bus.branch_target = 32'h40;
        tick();
        clear_ctl();
        checks++;
        if (bus.imem_addr !== 32'h80) begin
            failures++;
            $display("FAIL jump_priority: addr=%h expected=00000080", bus.imem_addr);
        end
    endtask

    task automatic test_reset_pending();
        tick();
        bus.b = 1; bus.branch_target = 32'h200; bus.imem_ready = 0;
        tick();
        bus.b = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: addr=%h valid=%b expected addr=0 valid=0", bus.imem_addr, bus.id_valid);
        end
        @(posedge clk);
        #1;
        rst = 0;
        bus.imem_ready = 1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== 4 * i || bus.id_inst !== 32'hA0 + i - 1) begin
                failures++;
                $display("FAIL after_reset[%0d]: addr=%h inst=%h expected addr=%h inst=%h", i, bus.imem_addr, bus.id_inst, 4 * i, 32'hA0 + i - 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.stall         = ($urandom_range(0, 4) == 0);
            bus.b             = ($urandom_range(0, 3) == 0);
            bus.jump          = ($urandom_range(0, 5) == 0);
            bus.branch_target = $urandom & 32'hFFFF_FFFC;
            bus.jump_target   = $urandom & 32'hFFFF_FFFC;
            bus.imem_ready    = ($urandom_range(0, 9) < 7);
            tick();
            checks++;
            if ({bus.imem_addr, bus.id_inst, bus.id_pc4, bus.id_valid} !== {m_pc, m_inst, m_pc4, m_valid}) begin
                failures++;
                $display("FAIL random[%0d]: addr=%h inst=%h pc4=%h valid=%b expected addr=%h inst=%h pc4=%h valid=%b",
                         i, bus.imem_addr, bus.id_inst, bus.id_pc4, bus.id_valid, m_pc, m_inst, m_pc4, m_valid);
            end
        end
        clear_ctl();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_wrap_jump();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It holds the PC, drives the instruction-memory address, and registers the fetched word into IF/ID. It consumes the taken/not-taken bit `b` from `branch_judge` and the jump request from decode, both evaluated on the instruction currently in ID, and redirects the PC. It also squashes wrong-path fetches or preserves the branch delay slot, depending on configuration.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `stall`  in  1: hazard unit hold. Freezes the PC and IF/ID.
- `b`  in  1: branch taken, from `branch_judge`, for the instruction in ID.
- `branch_target`  in  32: branch destination, computed in ID.
- `jump`  in  1: jump (j/jal/jr) decoded in ID.
- `jump_target`  in  32: jump destination.
- `imem_addr`  out  32: current PC, driven to instruction memory.
- `imem_data`  in  32: instruction word at `imem_addr`, combinational read.
- `imem_ready`  in  1: `imem_data` is valid this cycle.
- `id_inst`  out  32: IF/ID instruction (32'h0 = nop when bubble).
- `id_pc4`  out  32: IF/ID PC+4 of `id_inst`.
- `id_valid`  out  1: IF/ID holds a real instruction.

## Operation
- Definition: `redirect` = `id_valid` & (`jump` | `b`).
- Target selection: `jump_target` when `jump`=1, else `branch_target`. Jump wins if both are asserted.
- Reset values: PC=`RESET_PC`, `id_inst`=0, `id_pc4`=0, `id_valid`=0, FSM=NORMAL, pending target=0.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFF_FFFC+4 = 32'h0000_0000. No alignment check is made.
- Priority each cycle: `stall` > `redirect` > `imem_ready` > bubble.
  - **stall=1:** PC, IF/ID and FSM hold. `redirect` is ignored, because `b` is re-evaluated once forwarding operands are ready.
  - **redirect, no delay slot:** PC←target. IF/ID←bubble (`id_inst`=0, `id_valid`=0, `id_pc4`=0). This applies regardless of `imem_ready`.
  - **imem_ready=1, no redirect:** IF/ID←{`imem_data`, PC+4, valid=1}. PC←PC+4.
  - **imem_ready=0, no redirect:** PC holds. IF/ID←bubble.
- FSM (meaningful only with `DELAY_SLOT_EN`; otherwise it stays in NORMAL):
  - NORMAL → PENDING when `redirect` & !`stall` & !`imem_ready`. Latches the target, holds the PC at the delay-slot address, and loads a bubble into IF/ID.
  - NORMAL with `redirect` & !`stall` & `imem_ready`: IF/ID←delay slot {`imem_data`, PC+4, valid=1}. PC←target. FSM stays in NORMAL.
  - PENDING & !`stall` & `imem_ready`: IF/ID←delay slot. PC←pending target. FSM → NORMAL.
  - PENDING & `imem_ready`=0: PC holds. IF/ID←bubble.
  - `redirect` cannot occur in PENDING, because ID holds a bubble. If it is asserted anyway, it is ignored.
- Reset asserted mid-operation (including in PENDING) returns all state to the reset values immediately. The pending target is discarded.

## Timing
- `imem_addr` equals the PC register, so it changes only on a clock edge or on reset.
- Fetch latency is 1 cycle: a word presented with `imem_ready` in cycle n appears on `id_inst` in cycle n+1.
- Branch penalty, without `DELAY_SLOT_EN`: 1 bubble. The target is fetched in the cycle after the branch occupies ID.
- Branch penalty, with `DELAY_SLOT_EN`: 0 bubbles when `imem_ready`=1. In PENDING, the penalty is the number of memory wait cycles.
- `b`, `jump` and the targets are sampled only at the edge that ends the cycle in which the branch is in ID with `stall`=0.

## Configuration
- Macro: `FETCH_DELAY_SLOT_EN`.
- **Defined:** MIPS branch delay slot. The instruction after a branch or jump always enters ID and is never squashed. The PENDING state is used for the slow-memory case.
- **Undefined:** no delay slot. The IF-stage instruction is replaced by a bubble on every redirect. PENDING logic is not compiled in.

## Test plan
- **Reset and sequential fetch:** `RESET_PC`=0x0, `imem_ready`=1, words 0xA0..0xA3 → `id_inst` shows 0xA0,0xA1,… one per cycle, with `id_pc4`=0x4,0x8,…, and `imem_addr` at reset=0x0.
- **Taken branch, macro off:** branch at 0x10 with `b`=1 and target 0x40 → next `id_inst`=0 with `id_valid`=0, then the word at 0x40 with `id_pc4`=0x44.
- **Taken branch, macro on:** same stimulus → `id_inst`=word at 0x14 (valid) and `imem_addr`=0x40 in the same cycle. Repeat with `imem_ready`=0 for 2 cycles → PENDING, 2 bubbles, then the 0x14 word, then 0x40.
- **Stall versus redirect:** `stall`=1 together with `b`=1 for 3 cycles → PC and `id_inst` frozen and no redirect. When `stall` falls with `b`=1 → redirect occurs once.
- **Wrap-around and jump priority:** PC=0xFFFF_FFFC → `id_pc4`=0x0. Assert `jump`=1 (target 0x80) together with `b`=1 (target 0x40) → PC=0x80.
- **Reset mid-PENDING:** assert `rst` while in PENDING → asynchronous return to `RESET_PC`, `id_valid`=0, and the pending target is never fetched.
